// File: rtl/lsu_stage.sv
// Memory-access pipeline stage: single-outstanding load/store port, lane alignment, write-back handoff.
// Optional macro LSU_MISALIGN_CHECK_EN: flag misaligned H/W accesses and suppress their memory request.
module lsu_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_last,
    output logic              ready_last,
    input  logic [31:0]       pc,
    input  logic [31:0]       inst,
    input  logic [4:0]        rd,
    input  logic              R_wen,
    input  logic              mem_ren,
    input  logic              mem_wen,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] EX_result,
    input  logic [DATA_W-1:0] rs2_value,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_wr,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [3:0]        mem_req_wstrb,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_rdata,
    output logic              valid_next,
    input  logic              ready_next,
    output logic [31:0]       pc_next,
    output logic [31:0]       inst_next,
    output logic [4:0]        rd_next,
    output logic              R_wen_next,
    output logic [DATA_W-1:0] WB_data,
    output logic              misalign_next
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t            state_reg;
    logic [2:0]        funct3_reg;
    logic              accept;
    logic              is_mem;
    logic              misaligned;
    logic [3:0]        wstrb_calc;
    logic [DATA_W-1:0] wdata_calc;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] load_data;

    assign ready_last = (state_reg == IDLE) || ((state_reg == DONE) && ready_next);
    assign accept     = valid_last && ready_last;
    assign is_mem     = mem_ren || mem_wen;

`ifdef LSU_MISALIGN_CHECK_EN
    // funct3[1] set covers W plus the undefined encodings, which behave as word accesses
    assign misaligned = is_mem &&
                        (((funct3[1:0] == 2'b01) && EX_result[0]) ||
                         (funct3[1] && (EX_result[1:0] != 2'b00)));
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        wstrb_calc = 4'b0000;
        if (mem_wen) begin
            case (funct3[1:0])
                2'b00:   wstrb_calc = 4'b0001 << EX_result[1:0];
                2'b01:   wstrb_calc = 4'b0011 << {EX_result[1], 1'b0};
                default: wstrb_calc = 4'b1111;
            endcase
        end
    end

    // Replicate store data so every lane the strobe might select carries the right byte
    for (genvar gi = 0; gi < 4; gi++) begin : g_wlane
        assign wdata_calc[8*gi +: 8] =
            (funct3[1:0] == 2'b00) ? rs2_value[7:0] :
            (funct3[1:0] == 2'b01) ? rs2_value[8*(gi%2) +: 8] :
                                     rs2_value[8*gi +: 8];
    end

    // Zero-filling shift: lanes above bit 31 read as 0 for unaligned halfwords
    assign shifted = mem_resp_rdata >> {mem_req_addr[1:0], 3'b000};

    always_comb begin
        load_data = mem_resp_rdata;
        case (funct3_reg)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  load_data = {24'd0, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  load_data = {16'd0, shifted[15:0]};
            default: load_data = mem_resp_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            funct3_reg    <= 3'b000;
            mem_req_valid <= 1'b0;
            mem_req_wr    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            mem_req_wstrb <= 4'b0000;
            valid_next    <= 1'b0;
            pc_next       <= 32'd0;
            inst_next     <= 32'd0;
            rd_next       <= 5'd0;
            R_wen_next    <= 1'b0;
            WB_data       <= '0;
            misalign_next <= 1'b0;
        end else begin
            case (state_reg)
                REQ: if (mem_req_ready) begin
                    mem_req_valid <= 1'b0;
                    state_reg     <= WAIT;
                end
                WAIT: if (mem_resp_valid) begin
                    if (!mem_req_wr)
                        WB_data <= load_data;
                    valid_next <= 1'b1;
                    state_reg  <= DONE;
                end
                DONE: if (ready_next) begin
                    valid_next <= 1'b0;
                    state_reg  <= IDLE;
                end
                default: ;
            endcase

            // A new bundle overrides the DONE->IDLE transition above, giving back-to-back flow
            if (accept) begin
                pc_next       <= pc;
                inst_next     <= inst;
                rd_next       <= rd;
                R_wen_next    <= R_wen && !misaligned;
                misalign_next <= misaligned;
                funct3_reg    <= funct3;
                WB_data       <= EX_result;
                mem_req_wr    <= mem_wen;
                mem_req_addr  <= EX_result;
                mem_req_wdata <= wdata_calc;
                mem_req_wstrb <= wstrb_calc;
                if (is_mem && !misaligned) begin
                    mem_req_valid <= 1'b1;
                    valid_next    <= 1'b0;
                    state_reg     <= REQ;
                end else begin
                    valid_next    <= 1'b1;
                    state_reg     <= DONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu_stage.sv
// Scoreboard bench for lsu_stage: directed bundles push expected request/write-back records,
// monitors pop and compare on each handshake; a small responder answers memory requests.
module tb_lsu_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_last = 1'b0;
    logic        ready_last;
    logic [31:0] pc = 32'd0, inst = 32'd0;
    logic [4:0]  rd = 5'd0;
    logic        R_wen = 1'b0, mem_ren = 1'b0, mem_wen = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] EX_result = 32'd0, rs2_value = 32'd0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b1;
    logic        mem_req_wr;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_rdata = 32'd0;
    logic        valid_next;
    logic        ready_next = 1'b1;
    logic [31:0] pc_next, inst_next, WB_data;
    logic [4:0]  rd_next;
    logic        R_wen_next, misalign_next;

    lsu_stage dut (
        .clk(clk), .rst_n(rst_n),
        .valid_last(valid_last), .ready_last(ready_last),
        .pc(pc), .inst(inst), .rd(rd), .R_wen(R_wen),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .funct3(funct3),
        .EX_result(EX_result), .rs2_value(rs2_value),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_wr(mem_req_wr), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .valid_next(valid_next), .ready_next(ready_next),
        .pc_next(pc_next), .inst_next(inst_next), .rd_next(rd_next),
        .R_wen_next(R_wen_next), .WB_data(WB_data), .misalign_next(misalign_next)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] wb;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic        rwen;
        logic        mis;
    } wb_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
    } req_t;

    wb_t         wb_q[$];
    req_t        req_q[$];
    int          n_vec = 0;
    int          n_miss = 0;
    int          cyc = 0;
    logic [31:0] resp_word = 32'd0;
    logic        pend = 1'b0;
    logic        hold_resp = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory responder: one response per accepted request, one cycle after the handshake
    initial forever begin
        @(negedge clk);
        if (rst_n && mem_req_valid && mem_req_ready) pend = 1'b1;
        @(posedge clk);
        #2;
        if (!rst_n) begin
            pend = 1'b0;
            mem_resp_valid = 1'b0;
        end else if (mem_resp_valid) begin
            mem_resp_valid = 1'b0;
        end else if (pend && !hold_resp) begin
            mem_resp_valid = 1'b1;
            mem_resp_rdata = resp_word;
            pend = 1'b0;
        end
    end

    // Request monitor
    initial forever begin
        req_t e;
        @(negedge clk);
        if (rst_n && mem_req_valid && mem_req_ready) begin
            if (req_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL req_unexpected: got request addr 0x%08h, expected none", mem_req_addr);
            end else begin
                e = req_q.pop_front();
                resp_word = e.rdata;
                check("req_wr", 32'(mem_req_wr), 32'(e.wr));
                check("req_addr", mem_req_addr, e.addr);
                check("req_wstrb", 32'(mem_req_wstrb), 32'(e.wstrb));
                if (e.wr) check("req_wdata", mem_req_wdata, e.wdata);
                $display("req  wr=%0d addr=0x%08h wdata=0x%08h wstrb=%b", mem_req_wr, mem_req_addr, mem_req_wdata, mem_req_wstrb);
            end
        end
    end

    // Write-back monitor
    initial forever begin
        wb_t e;
        @(negedge clk);
        if (rst_n && valid_next && ready_next) begin
            if (wb_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL wb_unexpected: got WB_data 0x%08h, expected none", WB_data);
            end else begin
                e = wb_q.pop_front();
                check("wb_data", WB_data, e.wb);
                check("pc_next", pc_next, e.pc);
                check("inst_next", inst_next, e.inst);
                check("rd_next", 32'(rd_next), 32'(e.rd));
                check("R_wen_next", 32'(R_wen_next), 32'(e.rwen));
                check("misalign_next", 32'(misalign_next), 32'(e.mis));
                $display("wb   pc=0x%08h WB_data=0x%08h rd=%0d R_wen=%0d mis=%0d", pc_next, WB_data, rd_next, R_wen_next, misalign_next);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [31:0] p, input logic [31:0] i, input logic [4:0] r,
                        input logic rw, input logic ren, input logic wen, input logic [2:0] f3,
                        input logic [31:0] ex, input logic [31:0] rs2, output int acc);
        bit ok;
        ok = 1'b0;
        pc = p; inst = i; rd = r; R_wen = rw; mem_ren = ren; mem_wen = wen;
        funct3 = f3; EX_result = ex; rs2_value = rs2;
        valid_last = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (ready_last) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_miss++;
            $display("FAIL accept_timeout: got ready_last=0 for 50 cycles, expected 1 (pc 0x%08h)", p);
            valid_last = 1'b0;
            acc = -1;
            return;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        valid_last = 1'b0;
        mem_ren = 1'b0;
        mem_wen = 1'b0;
    endtask

    task automatic do_alu(input logic [31:0] p, input logic [31:0] ex, input logic [4:0] r, output int acc);
        wb_q.push_back('{wb: ex, pc: p, inst: 32'h00000013, rd: r, rwen: 1'b1, mis: 1'b0});
        send(p, 32'h00000013, r, 1'b1, 1'b0, 1'b0, 3'b000, ex, 32'd0, acc);
    endtask

    task automatic do_load(input logic [31:0] p, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] rdata, input logic [31:0] exp_wb, output int acc);
        req_q.push_back('{wr: 1'b0, addr: addr, wdata: 32'd0, wstrb: 4'b0000, rdata: rdata});
        wb_q.push_back('{wb: exp_wb, pc: p, inst: 32'h00000003, rd: 5'd10, rwen: 1'b1, mis: 1'b0});
        send(p, 32'h00000003, 5'd10, 1'b1, 1'b1, 1'b0, f3, addr, 32'd0, acc);
    endtask

    task automatic do_store(input logic [31:0] p, input logic [31:0] addr, input logic [2:0] f3,
                            input logic [31:0] rs2, input logic [3:0] strb, input logic [31:0] wdata,
                            output int acc);
        req_q.push_back('{wr: 1'b1, addr: addr, wdata: wdata, wstrb: strb, rdata: 32'd0});
        wb_q.push_back('{wb: addr, pc: p, inst: 32'h00000023, rd: 5'd0, rwen: 1'b0, mis: 1'b0});
        send(p, 32'h00000023, 5'd0, 1'b0, 1'b0, 1'b1, f3, addr, rs2, acc);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int a1, a2, acc;
        bit seen;

        // Reset state
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_valid_next", 32'(valid_next), 32'd0);
        check("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst_wstrb", 32'(mem_req_wstrb), 32'd0);
        check("rst_WB_data", WB_data, 32'd0);
        check("rst_misalign", 32'(misalign_next), 32'd0);
        check("rst_pc_next", pc_next, 32'd0);
        check("rst_inst_next", inst_next, 32'd0);
        check("rst_rd_next", 32'(rd_next), 32'd0);
        check("rst_R_wen_next", 32'(R_wen_next), 32'd0);
        check("rst_ready_last", 32'(ready_last), 32'd1);
        rst_n = 1'b1;
        tick();

        // ALU passthrough, 1-cycle latency, no request
        do_alu(32'h100, 32'h1234, 5'd5, acc);
        check("alu_valid_latency", 32'(valid_next), 32'd1);
        check("alu_no_req", 32'(mem_req_valid), 32'd0);
        check("alu_wb_early", WB_data, 32'h1234);
        tick();

        // LB with latency profile: valid_next only after REQ and WAIT
        do_load(32'h104, 32'h80000003, 3'b000, 32'h80FF0000, 32'hFFFFFF80, acc);
        check("lb_lat_req", 32'(valid_next), 32'd0);
        tick();
        check("lb_lat_wait", 32'(valid_next), 32'd0);
        tick();
        check("lb_lat_done", 32'(valid_next), 32'd1);
        tick();
        do_load(32'h108, 32'h80000003, 3'b100, 32'h80FF0000, 32'h00000080, acc);
        do_load(32'h10C, 32'h80000002, 3'b001, 32'h80011234, 32'hFFFF8001, acc);
        do_load(32'h110, 32'h80000002, 3'b101, 32'h80011234, 32'h00008001, acc);
        do_load(32'h114, 32'h00000010, 3'b010, 32'hDEADBEEF, 32'hDEADBEEF, acc);
        do_load(32'h118, 32'h00000001, 3'b000, 32'h00007F00, 32'h0000007F, acc);

        // Stores
        do_store(32'h120, 32'h80000002, 3'b001, 32'hCAFEBEEF, 4'b1100, 32'hBEEFBEEF, acc);
        do_store(32'h124, 32'h00000001, 3'b000, 32'h000000A5, 4'b0010, 32'hA5A5A5A5, acc);
        do_store(32'h128, 32'h00000040, 3'b010, 32'h12345678, 4'b1111, 32'h12345678, acc);
        repeat (5) tick();

        // Request backpressure, then write-back backpressure
        mem_req_ready = 1'b0;
        do_store(32'h130, 32'h00000044, 3'b010, 32'h0BADF00D, 4'b1111, 32'h0BADF00D, acc);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_req_valid", 32'(mem_req_valid), 32'd1);
            check("bp_req_addr", mem_req_addr, 32'h44);
            check("bp_req_wdata", mem_req_wdata, 32'h0BADF00D);
            check("bp_req_wstrb", 32'(mem_req_wstrb), 32'hF);
        end
        mem_req_ready = 1'b1;
        ready_next = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (valid_next) begin
                seen = 1'b1;
                break;
            end
        end
        check("bp_done_reached", 32'(seen), 32'd1);
        for (int k = 0; k < 2; k++) begin
            tick();
            check("bp_valid_hold", 32'(valid_next), 32'd1);
            check("bp_ready_last", 32'(ready_last), 32'd0);
            check("bp_wb_hold", WB_data, 32'h44);
            check("bp_pc_hold", pc_next, 32'h130);
        end
        ready_next = 1'b1;
        tick();

        // Back-to-back accepts from DONE, including DONE -> REQ
        do_alu(32'h200, 32'h0000000A, 5'd1, a1);
        do_alu(32'h204, 32'h0000000B, 5'd2, a2);
        check("b2b_accept_gap", 32'(a2 - a1), 32'd1);
        check("b2b_valid", 32'(valid_next), 32'd1);
        check("b2b_pc", pc_next, 32'h204);
        do_load(32'h208, 32'h00000020, 3'b010, 32'h55AA55AA, 32'h55AA55AA, a1);
        check("b2b_load_gap", 32'(a1 - a2), 32'd1);
        repeat (5) tick();

        // Reset while waiting for a response
        hold_resp = 1'b1;
        req_q.push_back('{wr: 1'b0, addr: 32'h30, wdata: 32'd0, wstrb: 4'b0000, rdata: 32'd0});
        send(32'h300, 32'h00000003, 5'd10, 1'b1, 1'b1, 1'b0, 3'b010, 32'h30, 32'd0, acc);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (!mem_req_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("wait_reached", 32'(seen), 32'd1);
        tick();
        rst_n = 1'b0;
        tick();
        tick();
        check("mid_rst_valid_next", 32'(valid_next), 32'd0);
        check("mid_rst_req_valid", 32'(mem_req_valid), 32'd0);
        check("mid_rst_WB_data", WB_data, 32'd0);
        check("mid_rst_pc_next", pc_next, 32'd0);
        check("mid_rst_ready_last", 32'(ready_last), 32'd1);
        hold_resp = 1'b0;
        rst_n = 1'b1;
        tick();
        do_load(32'h310, 32'h00000010, 3'b010, 32'h13572468, 32'h13572468, acc);
`ifdef LSU_MISALIGN_CHECK_EN
        wb_q.push_back('{wb: 32'h2, pc: 32'h314, inst: 32'h00000003, rd: 5'd10, rwen: 1'b0, mis: 1'b1});
        send(32'h314, 32'h00000003, 5'd10, 1'b1, 1'b1, 1'b0, 3'b010, 32'h2, 32'd0, acc);
        check("mis_no_req", 32'(mem_req_valid), 32'd0);
        check("mis_valid", 32'(valid_next), 32'd1);
`else
        do_load(32'h314, 32'h00000002, 3'b010, 32'h11223344, 32'h11223344, acc);
        check("unaligned_lw_misalign", 32'(misalign_next), 32'd0);
`endif

        // Drain both scoreboards
        for (int k = 0; k < 50; k++) begin
            if (wb_q.size() == 0 && req_q.size() == 0) break;
            tick();
        end
        repeat (2) tick();
        check("wb_queue_drained", 32'(wb_q.size()), 32'd0);
        check("req_queue_drained", 32'(req_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
